// File: rtl/axis_uart_tx_arbiter.sv
// axis_uart_tx_arbiter: round-robin arbiter that shares one UART transmit
// stream between NUM_PORTS AXI-Stream requesters. A requester keeps the grant
// until it sends tlast or MAX_BURST beats. This keeps one source's bytes out of
// another source's packet on the serial line.
// Optional feature: define AXIS_UART_ARB_ID_HEADER_EN to send a source-tag
// byte (8'hA0 | port index) ahead of every burst.
module axis_uart_tx_arbiter #(
    parameter int NUM_PORTS      = 4,
    parameter int AXI_DATA_WIDTH = 8,
    parameter int MAX_BURST      = 16
) (
    input  logic                                aclk,
    input  logic                                aresetn,
    input  logic [NUM_PORTS*AXI_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_PORTS-1:0]                s_axis_tvalid,
    input  logic [NUM_PORTS-1:0]                s_axis_tlast,
    output logic [NUM_PORTS-1:0]                s_axis_tready,
    output logic [AXI_DATA_WIDTH-1:0]           m_axis_tdata,
    output logic                                m_axis_tvalid,
    input  logic                                m_axis_tready,
    output logic [NUM_PORTS-1:0]                grant,
    output logic                                busy
);

    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CNT_W = $clog2(MAX_BURST + 1);

`ifdef AXIS_UART_ARB_ID_HEADER_EN
    typedef enum logic [1:0] {IDLE, XFER, HDR} state_t;
`else
    typedef enum logic {IDLE, XFER} state_t;
`endif

    state_t               state_q, state_d;
    logic [NUM_PORTS-1:0] grant_q, grant_d;
    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;

    logic [NUM_PORTS-1:0]      pick_oh;
    logic                      pick_found;
    logic [PTR_W-1:0]          next_ptr;
    logic [AXI_DATA_WIDTH-1:0] sel_data;
    logic                      sel_valid;
    logic                      sel_last;

    // Round-robin pick: first valid port scanning rr_ptr, rr_ptr+1, ... with wrap.
    always_comb begin
        pick_oh    = '0;
        pick_found = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (!pick_found && s_axis_tvalid[i] &&
                    ((int'(rr_ptr_q) + k) % NUM_PORTS) == i) begin
                    pick_oh[i] = 1'b1;
                    pick_found = 1'b1;
                end
            end
        end
    end

    // Pass-through mux for the granted port, plus the pointer value that follows it.
    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        next_ptr  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant_q[i]) begin
                sel_data  = s_axis_tdata[i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
                sel_valid = s_axis_tvalid[i];
                sel_last  = s_axis_tlast[i];
                next_ptr  = PTR_W'((i + 1) % NUM_PORTS);
            end
        end
    end

`ifdef AXIS_UART_ARB_ID_HEADER_EN
    logic [7:0] hdr_byte;

    // Source tag for the header: 8'hA0 with the owner index OR-ed into the low bits.
    always_comb begin
        hdr_byte = 8'hA0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant_q[i]) begin
                hdr_byte = 8'hA0 | 8'(i);
            end
        end
    end
`endif

    // Next-state logic and stream outputs; everything defaults to its idle value.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        rr_ptr_d      = rr_ptr_q;
        beat_cnt_d    = beat_cnt_q;
        s_axis_tready = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d    = pick_oh;
                    beat_cnt_d = '0;
`ifdef AXIS_UART_ARB_ID_HEADER_EN
                    state_d    = HDR;
`else
                    state_d    = XFER;
`endif
                end
            end
`ifdef AXIS_UART_ARB_ID_HEADER_EN
            HDR: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = AXI_DATA_WIDTH'(hdr_byte);
                if (m_axis_tready) begin
                    state_d = XFER;
                end
            end
`endif
            XFER: begin
                m_axis_tdata  = sel_data;
                m_axis_tvalid = sel_valid;
                s_axis_tready = grant_q & {NUM_PORTS{m_axis_tready}};
                if (sel_valid && m_axis_tready) begin
                    if (sel_last || beat_cnt_q == CNT_W'(MAX_BURST - 1)) begin
                        state_d    = IDLE;
                        grant_d    = '0;
                        beat_cnt_d = '0;
                        rr_ptr_d   = next_ptr;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                grant_d    = '0;
                beat_cnt_d = '0;
            end
        endcase
    end

    // State registers, cleared immediately when aresetn falls.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign grant = grant_q;
    assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_axis_uart_tx_arbiter.sv
// tb_axis_uart_tx_arbiter: self-checking bench for axis_uart_tx_arbiter.
// Each requester replays a list of beats. A cycle-level reference model tracks
// who owns the stream, how many beats that owner has sent and where the
// round-robin search starts. Observed grants and bytes are logged for the
// scenario-level checks.
`timescale 1ns/1ps
module tb_axis_uart_tx_arbiter;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int MB    = 4;
    localparam int DEPTH = 64;
    localparam int IW    = $clog2(N);
`ifdef AXIS_UART_ARB_ID_HEADER_EN
    localparam int HDR_BEATS = 1;
`else
    localparam int HDR_BEATS = 0;
`endif

    logic           aclk = 1'b0;
    logic           aresetn = 1'b1;
    logic [N*W-1:0] s_axis_tdata = '0;
    logic [N-1:0]   s_axis_tvalid = '0;
    logic [N-1:0]   s_axis_tlast = '0;
    logic [N-1:0]   s_axis_tready;
    logic [W-1:0]   m_axis_tdata;
    logic           m_axis_tvalid;
    logic           m_axis_tready = 1'b0;
    logic [N-1:0]   grant;
    logic           busy;

    int errors = 0;
    int checks = 0;

    // Per-port beat lists and replay positions
    logic [W-1:0] srcData [N][DEPTH];
    bit           srcLast [N][DEPTH];
    int           srcLen [N];
    int           srcPos [N];
    int           startCyc [N];
    logic [N-1:0] accPrev;
    int           validPct;
    int           readyMode;
    int           cyc;

    // Reference model state: current owner (-1 when idle), beats sent, search start
    int mOwner;
    int mBeats;
    int mPtr;
    bit mHdr;

    // Observations taken from the DUT
    logic [N-1:0] grantLog [$];
    logic [W-1:0] byteLog [$];
    logic [N-1:0] prevGrant;
    int           hsCount;

    axis_uart_tx_arbiter #(
        .NUM_PORTS      (N),
        .AXI_DATA_WIDTH (W),
        .MAX_BURST      (MB)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .grant         (grant),
        .busy          (busy)
    );

    // Free-running 100 MHz clock
    always #5 aclk = ~aclk;

    function automatic bit allDone();
        for (int p = 0; p < N; p++) begin
            if (srcPos[p] < srcLen[p]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic addBeat(input int p, input logic [W-1:0] data, input bit last);
        srcData[p][srcLen[p]] = data;
        srcLast[p][srcLen[p]] = last;
        srcLen[p]++;
    endtask

    task automatic doReset();
        aresetn       = 1'b0;
        m_axis_tready = 1'b0;
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
        s_axis_tdata  = '0;
        for (int p = 0; p < N; p++) begin
            srcLen[p]   = 0;
            srcPos[p]   = 0;
            startCyc[p] = 0;
        end
        accPrev   = '0;
        validPct  = 100;
        readyMode = 0;
        repeat (2) @(posedge aclk);
        #1;
        aresetn   = 1'b1;
        mOwner    = -1;
        mBeats    = 0;
        mPtr      = 0;
        mHdr      = 1'b0;
        cyc       = 0;
        hsCount   = 0;
        prevGrant = '0;
        grantLog.delete();
        byteLog.delete();
    endtask

    // One clock cycle: drive inputs, compare outputs against the model at the
    // falling edge, advance the model, then let the rising edge happen.
    task automatic step();
        logic [N-1:0] acc;
        logic [N-1:0] expGrant;
        logic [N-1:0] expTr;
        logic         expMv;
        logic         expBusy;
        logic [W-1:0] expData;
        acc = '0;
        for (int p = 0; p < N; p++) begin
            if (!(s_axis_tvalid[IW'(p)] && !accPrev[IW'(p)])) begin
                if (srcPos[p] < srcLen[p] && cyc >= startCyc[p] &&
                    int'($urandom_range(99)) < validPct) begin
                    s_axis_tvalid[IW'(p)]  = 1'b1;
                    s_axis_tlast[IW'(p)]   = srcLast[p][srcPos[p]];
                    s_axis_tdata[p*W +: W] = srcData[p][srcPos[p]];
                end else begin
                    s_axis_tvalid[IW'(p)]  = 1'b0;
                    s_axis_tlast[IW'(p)]   = 1'b0;
                    s_axis_tdata[p*W +: W] = W'($urandom);
                end
            end
        end
        case (readyMode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = ~m_axis_tready;
            default: m_axis_tready = 1'($urandom_range(1));
        endcase

        @(negedge aclk);
        expBusy = (mOwner >= 0);
        if (mOwner < 0) begin
            expGrant = '0;
            expMv    = 1'b0;
            expTr    = '0;
            expData  = '0;
        end
`ifdef AXIS_UART_ARB_ID_HEADER_EN
        else if (mHdr) begin
            expGrant = N'(1) << mOwner;
            expMv    = 1'b1;
            expTr    = '0;
            expData  = W'(8'hA0 | 8'(mOwner));
        end
`endif
        else begin
            expGrant = N'(1) << mOwner;
            expMv    = s_axis_tvalid[IW'(mOwner)];
            expTr    = m_axis_tready ? expGrant : '0;
            expData  = srcData[mOwner][srcPos[mOwner]];
        end

        checks++;
        if (grant !== expGrant) begin
            errors++;
            $display("[TB] FAIL grant cyc=%0d: got %b expected %b", cyc, grant, expGrant);
        end
        checks++;
        if (busy !== expBusy) begin
            errors++;
            $display("[TB] FAIL busy cyc=%0d: got %b expected %b", cyc, busy, expBusy);
        end
        checks++;
        if (m_axis_tvalid !== expMv) begin
            errors++;
            $display("[TB] FAIL m_tvalid cyc=%0d: got %b expected %b", cyc, m_axis_tvalid, expMv);
        end
        checks++;
        if (s_axis_tready !== expTr) begin
            errors++;
            $display("[TB] FAIL s_tready cyc=%0d: got %b expected %b", cyc, s_axis_tready, expTr);
        end
        if (expMv) begin
            checks++;
            if (m_axis_tdata !== expData) begin
                errors++;
                $display("[TB] FAIL m_tdata cyc=%0d: got %h expected %h", cyc, m_axis_tdata, expData);
            end
        end

        if (grant !== '0 && prevGrant === '0) grantLog.push_back(grant);
        prevGrant = grant;
        if (m_axis_tvalid === 1'b1 && m_axis_tready) begin
            byteLog.push_back(m_axis_tdata);
            hsCount++;
        end

        if (mOwner < 0) begin
            for (int k = 0; k < N; k++) begin
                if (mOwner < 0 && s_axis_tvalid[IW'((mPtr + k) % N)]) begin
                    mOwner = (mPtr + k) % N;
                    mBeats = 0;
                    mHdr   = (HDR_BEATS != 0);
                end
            end
        end
`ifdef AXIS_UART_ARB_ID_HEADER_EN
        else if (mHdr) begin
            if (m_axis_tready) mHdr = 1'b0;
        end
`endif
        else if (expMv && m_axis_tready) begin
            acc[IW'(mOwner)] = 1'b1;
            mBeats++;
            if (srcLast[mOwner][srcPos[mOwner]] || mBeats == MB) begin
                mPtr   = (mOwner + 1) % N;
                mOwner = -1;
                mBeats = 0;
            end
        end

        @(posedge aclk);
        #1;
        for (int p = 0; p < N; p++) begin
            if (acc[IW'(p)]) srcPos[p]++;
        end
        accPrev = acc;
        cyc++;
    endtask

    task automatic runUntilDone(input string name, input int budget);
        int n;
        n = 0;
        while (!(allDone() && mOwner < 0) && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("[TB] FAIL %s_timeout: got %0d cycles, required fewer than %0d", name, n, budget);
        end
    endtask

    task automatic test_reset();
        s_axis_tvalid = '1;
        s_axis_tdata  = {N{8'h5A}};
        m_axis_tready = 1'b1;
        #1 aresetn = 1'b0;
        #1;
        checks++;
        if (grant !== '0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_grant_busy: got %b/%b expected 0000/0", grant, busy);
        end
        checks++;
        if (s_axis_tready !== '0 || m_axis_tvalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_valid_ready: got %b/%b expected 0000/0", s_axis_tready, m_axis_tvalid);
        end
        checks++;
        if (m_axis_tdata !== '0) begin
            errors++;
            $display("[TB] FAIL reset_tdata: got %h expected 00", m_axis_tdata);
        end
        doReset();
    endtask

    task automatic test_single_request();
        logic [W-1:0] expBytes [$];
        doReset();
        addBeat(2, 8'h11, 1'b0);
        addBeat(2, 8'h22, 1'b0);
        addBeat(2, 8'h33, 1'b1);
        runUntilDone("single", 50);
`ifdef AXIS_UART_ARB_ID_HEADER_EN
        expBytes.push_back(8'hA2);
`endif
        expBytes.push_back(8'h11);
        expBytes.push_back(8'h22);
        expBytes.push_back(8'h33);
        checks++;
        if (byteLog.size() != expBytes.size()) begin
            errors++;
            $display("[TB] FAIL single_count: got %0d bytes expected %0d", byteLog.size(), expBytes.size());
        end else begin
            for (int i = 0; i < expBytes.size(); i++) begin
                checks++;
                if (byteLog[i] !== expBytes[i]) begin
                    errors++;
                    $display("[TB] FAIL single_byte%0d: got %h expected %h", i, byteLog[i], expBytes[i]);
                end
            end
        end
        // Pointer now sits at port 3, so port 3 beats port 0 in the next contest
        addBeat(0, 8'hA5, 1'b1);
        addBeat(3, 8'h3C, 1'b1);
        runUntilDone("single_ptr", 50);
        checks++;
        if (grantLog.size() != 3) begin
            errors++;
            $display("[TB] FAIL single_grants: got %0d grants expected 3", grantLog.size());
        end else begin
            checks++;
            if (grantLog[0] !== 4'b0100 || grantLog[1] !== 4'b1000 || grantLog[2] !== 4'b0001) begin
                errors++;
                $display("[TB] FAIL single_order: got %b,%b,%b expected 0100,1000,0001",
                         grantLog[0], grantLog[1], grantLog[2]);
            end
        end
    endtask

    task automatic test_round_robin();
        doReset();
        for (int i = 0; i < 4; i++) begin
            addBeat(0, W'(8'h10 + i), 1'b1);
            addBeat(3, W'(8'h30 + i), 1'b1);
        end
        runUntilDone("rr", 100);
        checks++;
        if (grantLog.size() != 8) begin
            errors++;
            $display("[TB] FAIL rr_grants: got %0d grants expected 8", grantLog.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (grantLog[i] !== ((i % 2 == 0) ? 4'b0001 : 4'b1000)) begin
                    errors++;
                    $display("[TB] FAIL rr_order%0d: got %b expected %b", i, grantLog[i],
                             (i % 2 == 0) ? 4'b0001 : 4'b1000);
                end
            end
        end
    endtask

    task automatic test_max_burst();
        doReset();
        for (int i = 1; i <= 10; i++) addBeat(1, W'(8'h40 + i), i == 10);
        addBeat(0, 8'hE1, 1'b0);
        addBeat(0, 8'hE2, 1'b1);
        startCyc[0] = 1;
        runUntilDone("maxburst", 100);
        checks++;
        if (hsCount != 12 + 4 * HDR_BEATS) begin
            errors++;
            $display("[TB] FAIL maxburst_beats: got %0d expected %0d", hsCount, 12 + 4 * HDR_BEATS);
        end
        checks++;
        if (grantLog.size() != 4) begin
            errors++;
            $display("[TB] FAIL maxburst_grants: got %0d grants expected 4", grantLog.size());
        end else begin
            checks++;
            if (grantLog[0] !== 4'b0010 || grantLog[1] !== 4'b0001 ||
                grantLog[2] !== 4'b0010 || grantLog[3] !== 4'b0010) begin
                errors++;
                $display("[TB] FAIL maxburst_order: got %b,%b,%b,%b expected 0010,0001,0010,0010",
                         grantLog[0], grantLog[1], grantLog[2], grantLog[3]);
            end
        end
    endtask

    task automatic test_backpressure();
        doReset();
        readyMode = 1;
        for (int i = 0; i < 5; i++) addBeat(0, W'(8'h70 + i), i == 4);
        runUntilDone("bp", 60);
        checks++;
        if (hsCount != 5 + HDR_BEATS) begin
            errors++;
            $display("[TB] FAIL bp_handshakes: got %0d expected %0d", hsCount, 5 + HDR_BEATS);
        end
    endtask

    task automatic test_reset_mid_burst();
        int n;
        doReset();
        for (int i = 0; i < 5; i++) addBeat(2, W'(8'h90 + i), i == 4);
        n = 0;
        while (hsCount < 2 + HDR_BEATS && n < 50) begin
            step();
            n++;
        end
        checks++;
        if (n >= 50) begin
            errors++;
            $display("[TB] FAIL midreset_timeout: got %0d cycles, required fewer than 50", n);
        end
        #2 aresetn = 1'b0;
        #1;
        checks++;
        if (grant !== '0 || busy !== 1'b0 || s_axis_tready !== '0 ||
            m_axis_tvalid !== 1'b0 || m_axis_tdata !== '0) begin
            errors++;
            $display("[TB] FAIL midreset_outputs: got grant=%b busy=%b tready=%b mvalid=%b mdata=%h expected all zero",
                     grant, busy, s_axis_tready, m_axis_tvalid, m_axis_tdata);
        end
        doReset();
        addBeat(3, 8'hC3, 1'b1);
        addBeat(1, 8'hC1, 1'b1);
        runUntilDone("midreset_after", 50);
        checks++;
        if (grantLog.size() < 1 || grantLog[0] !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL midreset_first_grant: got %b expected 0010",
                     (grantLog.size() > 0) ? grantLog[0] : 4'b0000);
        end
    endtask

`ifdef AXIS_UART_ARB_ID_HEADER_EN
    task automatic test_id_header();
        doReset();
        addBeat(3, 8'h55, 1'b1);
        runUntilDone("hdr", 30);
        checks++;
        if (byteLog.size() != 2 || byteLog[0] !== 8'hA3 || byteLog[1] !== 8'h55) begin
            errors++;
            $display("[TB] FAIL hdr_bytes: got %0d bytes first %h expected A3,55",
                     byteLog.size(), (byteLog.size() > 0) ? byteLog[0] : 8'h00);
        end
    endtask
`endif

    task automatic test_random();
        int total;
        doReset();
        readyMode = 2;
        validPct  = 70;
        total     = 0;
        for (int p = 0; p < N; p++) begin
            for (int k = 0; k < 3; k++) begin
                int len;
                len = int'($urandom_range(1, 6));
                for (int i = 0; i < len; i++) addBeat(p, W'($urandom), i == len - 1);
                total += len;
            end
        end
        runUntilDone("random", 3000);
        checks++;
        if (hsCount < total) begin
            errors++;
            $display("[TB] FAIL random_handshakes: got %0d expected at least %0d", hsCount, total);
        end
    endtask

    // Scenario sequence and final summary
    initial begin
        $display("[TB] starting axis_uart_tx_arbiter bench");
        test_reset();
        test_single_request();
        test_round_robin();
        test_max_burst();
        test_backpressure();
        test_reset_mid_burst();
`ifdef AXIS_UART_ARB_ID_HEADER_EN
        test_id_header();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time limit so the run always ends
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no completion, required finish before 2 ms");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
